// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw push-button levels in, debounced levels and edge pulses out.
interface key_debouncer_if #(
    parameter int w_key = 4
);
    logic [w_key-1:0] key_raw;
    logic [w_key-1:0] key_db;
    logic [w_key-1:0] key_pressed;
    logic [w_key-1:0] key_released;
    modport master (output key_raw, input key_db, key_pressed, key_released);
    modport slave (input key_raw, output key_db, key_pressed, key_released);
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: per-key two-flop synchroniser plus stability counter.
// Emits the clean level and one-cycle press/release pulses.
module key_debouncer #(
    parameter int clk_mhz        = 50,
    parameter int w_key          = 4,
    parameter int debounce_us    = 10000,
    parameter int key_active_low = 0
) (
    input logic            clk,
    input logic            rst,
    key_debouncer_if.slave bus
);
    localparam int N  = clk_mhz * debounce_us;
    localparam int CW = (N < 2) ? 1 : $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    if (N < 2) begin : g_bad_n
        $error("key_debouncer: clk_mhz * debounce_us must be at least 2");
    end
    logic [w_key-1:0] w_in;
    logic [w_key-1:0] r_s1;
    logic [w_key-1:0] r_s2;
    logic [w_key-1:0] r_db;
    logic [w_key-1:0] r_pressed;
    logic [w_key-1:0] r_released;
    logic [CW-1:0]    r_cnt [w_key];
    assign w_in = bus.key_raw ^ {w_key{key_active_low != 0}};
    // Any sample agreeing with db discards the partial count; commit on the Nth disagreeing sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_db       <= '0;
            r_pressed  <= '0;
            r_released <= '0;
            for (int i = 0; i < w_key; i++) r_cnt[i] <= '0;
        end else begin
            r_s1 <= w_in;
            r_s2 <= r_s1;
            for (int i = 0; i < w_key; i++) begin
                r_pressed[i]  <= 1'b0;
                r_released[i] <= 1'b0;
                if (r_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != LAST) begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end else begin
                    r_db[i]       <= r_s2[i];
                    r_cnt[i]      <= '0;
                    r_pressed[i]  <= r_s2[i];
                    r_released[i] <= !r_s2[i];
                end
            end
        end
    end
    assign bus.key_db       = r_db;
    assign bus.key_pressed  = r_pressed;
    assign bus.key_released = r_released;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed scenarios plus randomized run against a sample-window model.
module tb_key_debouncer;
    localparam int N = 4;
    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [3:0] raw1 = 4'h0;
    logic [3:0] raw2 = 4'hF;
    int         checks = 0;
    int         errors = 0;
    always #5 clk = ~clk;
    key_debouncer_if #(.w_key(4)) bus1 ();
    key_debouncer_if #(.w_key(4)) bus2 ();
    assign bus1.key_raw = raw1;
    assign bus2.key_raw = raw2;
    key_debouncer #(.clk_mhz(1), .w_key(4), .debounce_us(4), .key_active_low(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );
    key_debouncer #(.clk_mhz(1), .w_key(4), .debounce_us(4), .key_active_low(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );
    // Model: a key takes level v once the last N synchronised samples (raw from edges t-2..t-N-1) all equal v.
    logic [3:0] q [$];
    logic [3:0] m_db = '0;
    logic [3:0] m_pr = '0;
    logic [3:0] m_rl = '0;
    logic       m_v;
    logic       m_same;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q = {};
            repeat (N + 1) q.push_back(4'h0);
            m_db = '0;
            m_pr = '0;
            m_rl = '0;
        end else begin
            m_pr = '0;
            m_rl = '0;
            for (int i = 0; i < 4; i++) begin
                m_v    = q[0][i];
                m_same = 1'b1;
                for (int j = 1; j < N; j++) if (q[j][i] != m_v) m_same = 1'b0;
                if (m_same && m_v != m_db[i]) begin
                    m_db[i] = m_v;
                    m_pr[i] = m_v;
                    m_rl[i] = !m_v;
                end
            end
            q.push_back(raw1);
            void'(q.pop_front());
        end
    end
    task automatic settle(input logic [3:0] v);
        raw1 = v;
        repeat (12) @(negedge clk);
    endtask
    task automatic test_reset;
        raw1 = 4'hF;
        rst  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus1.key_db, bus1.key_pressed, bus1.key_released} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs got %h exp 000", {bus1.key_db, bus1.key_pressed, bus1.key_released});
            end
        end
        rst = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (bus1.key_db !== (c >= 6 ? 4'hF : 4'h0) || bus1.key_pressed !== (c == 6 ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL reset_release c=%0d got db %h pr %h exp db %h pr %h", c, bus1.key_db,
                         bus1.key_pressed, (c >= 6 ? 4'hF : 4'h0), (c == 6 ? 4'hF : 4'h0));
            end
        end
        checks++;
        if (bus2.key_db !== 4'h0) begin
            errors++;
            $display("FAIL reset_lowactive_db got %h exp 0", bus2.key_db);
        end
    endtask
    task automatic test_clean_press;
        settle(4'h0);
        raw1 = 4'h1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (bus1.key_db !== (c >= 6 ? 4'h1 : 4'h0) || bus1.key_pressed !== (c == 6 ? 4'h1 : 4'h0) ||
                bus1.key_released !== 4'h0) begin
                errors++;
                $display("FAIL press_k0 c=%0d got db %h pr %h rl %h", c, bus1.key_db, bus1.key_pressed,
                         bus1.key_released);
            end
        end
        raw1 = 4'h0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (bus1.key_db !== (c >= 6 ? 4'h0 : 4'h1) || bus1.key_released !== (c == 6 ? 4'h1 : 4'h0) ||
                bus1.key_pressed !== 4'h0) begin
                errors++;
                $display("FAIL release_k0 c=%0d got db %h pr %h rl %h", c, bus1.key_db, bus1.key_pressed,
                         bus1.key_released);
            end
        end
    endtask
    task automatic test_glitch;
        settle(4'h0);
        raw1 = 4'h2;
        repeat (3) @(negedge clk);
        raw1 = 4'h0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            checks++;
            if ({bus1.key_db, bus1.key_pressed, bus1.key_released} !== 12'h000) begin
                errors++;
                $display("FAIL glitch_k1 c=%0d got %h exp 000", c, {bus1.key_db, bus1.key_pressed, bus1.key_released});
            end
        end
    endtask
    task automatic test_bounce;
        logic p [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int   pulses = 0;
        settle(4'h0);
        for (int j = 0; j < 7; j++) begin
            raw1[2] = p[j];
            @(negedge clk);
            pulses += int'(bus1.key_pressed[2]);
            checks++;
            if (bus1.key_db[2] !== 1'b0) begin
                errors++;
                $display("FAIL bounce_early j=%0d got db %b exp 0", j, bus1.key_db[2]);
            end
        end
        raw1[2] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            pulses += int'(bus1.key_pressed[2]);
            checks++;
            if (bus1.key_db[2] !== (c >= 6)) begin
                errors++;
                $display("FAIL bounce_rise c=%0d got db %b exp %b", c, bus1.key_db[2], (c >= 6));
            end
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulses got %0d exp 1", pulses);
        end
    endtask
    task automatic test_simultaneous_reset;
        settle(4'h0);
        raw1 = 4'h9;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (bus1.key_db !== (c == 6 ? 4'h9 : 4'h0) || bus1.key_pressed !== (c == 6 ? 4'h9 : 4'h0)) begin
                errors++;
                $display("FAIL simul_press c=%0d got db %h pr %h", c, bus1.key_db, bus1.key_pressed);
            end
        end
        raw1 = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus1.key_db, bus1.key_pressed, bus1.key_released} !== 12'h000) begin
            errors++;
            $display("FAIL midcount_reset got %h exp 000", {bus1.key_db, bus1.key_pressed, bus1.key_released});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checks++;
            if (bus1.key_released !== 4'h0 || bus1.key_db !== 4'h0) begin
                errors++;
                $display("FAIL post_reset c=%0d got db %h rl %h exp 0 0", c, bus1.key_db, bus1.key_released);
            end
        end
    endtask
    task automatic test_polarity;
        checks++;
        if (bus2.key_db !== 4'h0) begin
            errors++;
            $display("FAIL polarity_idle got %h exp 0", bus2.key_db);
        end
        raw2 = 4'hE;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            checks++;
            if (bus2.key_db !== (c >= 6 ? 4'h1 : 4'h0) || bus2.key_pressed !== (c == 6 ? 4'h1 : 4'h0)) begin
                errors++;
                $display("FAIL polarity_press c=%0d got db %h pr %h", c, bus2.key_db, bus2.key_pressed);
            end
        end
    endtask
    task automatic test_random;
        settle(4'h0);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (bus1.key_db !== m_db || bus1.key_pressed !== m_pr || bus1.key_released !== m_rl) begin
                errors++;
                $display("FAIL random c=%0d got db %h pr %h rl %h exp db %h pr %h rl %h", c, bus1.key_db,
                         bus1.key_pressed, bus1.key_released, m_db, m_pr, m_rl);
            end
            if (!rst) rst = 1'b1;
            else if ($urandom_range(199) == 0) rst = 1'b0;
            for (int i = 0; i < 4; i++) if ($urandom_range(4) == 0) raw1[i] = ~raw1[i];
        end
        rst = 1'b1;
    endtask
    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous_reset();
        test_polarity();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
